// File: rtl/uart_tx_fifo_bridge.sv
// Byte FIFO feeding an 8N1 UART transmitter; bytes offered while the FIFO is full are dropped and counted.
// Optional build macro UART_TX_CRLF_EN: each popped 0x0A is sent as 0x0D followed by 0x0A.
module uart_tx_fifo_bridge #(
    parameter int CLK_HZ = 125000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic [1:0]               state_dbg
);

    // Handshake: in_valid offers in_byte for exactly one cycle with no ready;
    // the byte is stored when level < DEPTH and otherwise dropped and counted.

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [LW-1:0]    FULL     = LW'(DEPTH);
    localparam logic [CW-1:0]    BIT_LAST = CW'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             lf_pend_q, lf_pend_d;
    logic [7:0]       mem_q [DEPTH];

    logic       push, pop, drop, bit_end;
    logic [7:0] head, load_val;
    logic       load_lf;

    always_comb begin
        head = mem_q[rd_ptr_q];
`ifdef UART_TX_CRLF_EN
        load_lf  = (head == 8'h0A);
        load_val = load_lf ? 8'h0D : head;
`else
        load_lf  = 1'b0;
        load_val = head;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        lf_pend_d  = lf_pend_q;
        pop        = 1'b0;
        bit_end    = (cnt_q == BIT_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = load_val;
                    lf_pend_d = load_lf;
                    cnt_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d = '0;
                    // A pending LF frame takes priority over the FIFO and uses no slot.
                    if (lf_pend_q) begin
                        lf_pend_d = 1'b0;
                        shift_d   = 8'h0A;
                        state_d   = S_START;
                    end else if (level_q != '0) begin
                        pop       = 1'b1;
                        shift_d   = load_val;
                        lf_pend_d = load_lf;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // txd is registered from the next state so it lines up with state_q.
        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        push       = in_valid && (level_q != FULL);
        drop       = in_valid && (level_q == FULL);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != CNT_MAX) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            lf_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            lf_pend_q  <= lf_pend_d;
        end
    end

    // Storage needs no reset; the zeroed pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_byte;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != S_IDLE);
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// Bench for uart_tx_fifo_bridge: directed pushes, a line decoder as monitor, expected frames in a queue.
module tb_uart_tx_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       txd;
    logic       busy;
    logic [2:0] level;
    logic       overflow;
    logic [3:0] drop_count;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int frames_seen = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_fifo_bridge #(
        .CLK_HZ(1000),
        .BAUD(100),
        .DEPTH(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .txd(txd),
        .busy(busy),
        .level(level),
        .overflow(overflow),
        .drop_count(drop_count),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_in_budget", (n < budget), 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % 10 == 5) begin
                if (mon_cnt == 5) begin
                    check("start_bit_mid", txd, 0);
                end else if (mon_cnt < 95) begin
                    mon_byte[(mon_cnt / 10) - 1] = txd;
                end else begin
                    check("stop_bit_mid", txd, 1);
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", mon_byte, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("frame_byte", mon_byte, exp_b);
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int f0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        tick();

        // single 0x55: start at push+2, busy high in last stop cycle, low one cycle later
        start_q.delete();
        exp_q.push_back(8'h55);
        p = cyc;
        push_byte(8'h55);
        while (cyc < p + 101) tick();
        check("busy_last_stop", busy, 1);
        tick();
        check("busy_fall", busy, 0);
        check("single_start_cycle", (start_q.size() > 0) ? start_q[0] : -1, p + 2);
        check("single_level", level, 0);
        wait_idle(50);

        // two consecutive pushes: back-to-back frames 100 cycles apart
        start_q.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        in_valid = 1'b1;
        in_byte  = 8'h41;
        tick();
        in_byte  = 8'h42;
        tick();
        in_valid = 1'b0;
        wait_idle(400);
        check("b2b_frames", start_q.size(), 2);
        check("b2b_gap", (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, 100);
        check("b2b_level", level, 0);

        // ten pushes in a row: one popped, four buffered, five dropped
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
        f0 = frames_seen;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_byte = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("burst_drop_count", drop_count, 5);
        check("burst_overflow", overflow, 1);
        check("burst_level", level, 4);
        wait_idle(700);
        check("burst_frames", frames_seen - f0, 5);

        // 20 drops while full: counter saturates at 15
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h20 + 8'(i));
        in_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            in_byte = 8'h20 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("sat_drop_count", drop_count, 15);
        check("sat_overflow", overflow, 1);
        wait_idle(700);

        // reset at cycle 40 of a frame with 3 bytes queued
        do_reset();
        start_q.delete();
        p = cyc;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_byte = 8'h31 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("midrst_level_before", level, 3);
        while (cyc < p + 42) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_txd", txd, 1);
        check("midrst_level", level, 0);
        check("midrst_busy", busy, 0);
        f0 = frames_seen;
        repeat (300) tick();
        check("midrst_no_frames", frames_seen - f0, 0);
        check("midrst_starts", start_q.size(), 1);

        // in_valid held during reset with the FIFO full is not a drop
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_byte = 8'h60 + 8'(i);
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rstvalid_drop_count", drop_count, 0);
        check("rstvalid_overflow", overflow, 0);
        check("rstvalid_level", level, 0);
        repeat (150) tick();

        // line feed handling
        do_reset();
        f0 = frames_seen;
`ifdef UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        push_byte(8'h0A);
        wait_idle(400);
        check("lf_frames", frames_seen - f0, 2);
`else
        exp_q.push_back(8'h0A);
        push_byte(8'h0A);
        wait_idle(400);
        check("lf_frames", frames_seen - f0, 1);
`endif
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
